// File: rtl/cpu_defs.sv
// Shared CPU definitions: reset PC, fetch-responder state encoding and the
// IF exception-flag bundle {adee, adfe} used by ID/MEM exception coding.
package cpu_defs;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_WAIT  = 2'd1,
    FETCH_RESP  = 2'd2,
    FETCH_DRAIN = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic adee;
    logic adfe;
  } ic_if_t;

  localparam ic_if_t IC_IF_NONE = '{adee: 1'b0, adfe: 1'b0};
  localparam ic_if_t IC_IF_ADEE = '{adee: 1'b1, adfe: 1'b0};
  localparam ic_if_t IC_IF_ADFE = '{adee: 1'b0, adfe: 1'b1};

endpackage

// File: rtl/imem_addr_check.sv
// Combinational fetch-address decode: misalignment, out-of-range and the
// SRAM word address relative to BASE_PC.
module imem_addr_check
  import cpu_defs::*;
#(
  parameter logic [31:0] BASE_PC = RESET_PC,
  parameter int          DEPTH   = 1024,
  parameter int          AW      = 10
) (
  input  logic [31:0]   pc,
  output logic          misaligned,
  output logic          out_of_range,
  output logic [AW-1:0] word_addr
);

  logic [31:0] offset_s;

  // With a word-aligned BASE_PC, a PC below the base wraps to an offset at or
  // above the window size, so one unsigned compare covers both range ends.
  assign offset_s     = pc - BASE_PC;
  assign misaligned   = (offset_s[1:0] != 2'b00);
  assign out_of_range = (offset_s >= (32'(DEPTH) << 2));
  assign word_addr    = offset_s[AW+1:2];

endmodule

// File: rtl/imem_fetch_responder.sv
// Instruction-memory responder: accepts IF fetch requests, issues one SRAM
// read at a time with fixed latency and returns the word or an error flag.
module imem_fetch_responder
  import cpu_defs::*;
#(
  parameter logic [31:0] BASE_PC = RESET_PC,
  parameter int          DEPTH   = 1024,
  parameter int          AW      = 10,
  parameter int          MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [31:0]   if_pc,
  input  logic          if_flush,
  output logic [31:0]   if_inst,
  output logic          if_inst_valid,
  output logic          if_delay_fetch,
  output logic          if_adee,
  output logic          if_adfe,
  output logic          mem_en,
  output logic [AW-1:0] mem_addr,
  input  logic [31:0]   mem_rdata
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] LAT_INIT = CW'(MEM_LAT - 1);

  fetch_state_e  state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [31:0]   inst_r, inst_s;
  ic_if_t        flags_r, flags_s;
  logic          accept_s;
  logic          misaligned_s, out_of_range_s;
  logic [AW-1:0] word_addr_s;

  imem_addr_check #(
    .BASE_PC(BASE_PC),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_addr_check (
    .pc          (if_pc),
    .misaligned  (misaligned_s),
    .out_of_range(out_of_range_s),
    .word_addr   (word_addr_s)
  );

  // Fetch FSM next-state, latency countdown and response capture
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    inst_s   = inst_r;
    flags_s  = flags_r;
    accept_s = 1'b0;
    case (state_r)
      FETCH_IDLE: begin
        if (if_req && !if_flush) begin
          if (misaligned_s) begin
            inst_s  = 32'h0000_0000;
            flags_s = IC_IF_ADEE;
            state_s = FETCH_RESP;
          end else if (out_of_range_s) begin
            inst_s  = 32'h0000_0000;
            flags_s = IC_IF_ADFE;
            state_s = FETCH_RESP;
          end else begin
            accept_s = 1'b1;
            cnt_s    = LAT_INIT;
            state_s  = FETCH_WAIT;
          end
        end else begin
          state_s = FETCH_IDLE;
        end
      end
      FETCH_WAIT: begin
        if (cnt_r == '0) begin
          // Data lands this cycle, so a flush here leaves nothing in flight.
          if (if_flush) begin
            state_s = FETCH_IDLE;
          end else begin
            inst_s  = mem_rdata;
            flags_s = IC_IF_NONE;
            state_s = FETCH_RESP;
          end
        end else begin
          cnt_s   = cnt_r - CW'(1);
          state_s = if_flush ? FETCH_DRAIN : FETCH_WAIT;
        end
      end
      FETCH_RESP: begin
        flags_s = IC_IF_NONE;
        state_s = FETCH_IDLE;
      end
      FETCH_DRAIN: begin
        if (cnt_r == '0) begin
          state_s = FETCH_IDLE;
        end else begin
          cnt_s = cnt_r - CW'(1);
        end
      end
      default: begin
        state_s = FETCH_IDLE;
      end
    endcase
  end

  // State, counter and response registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= FETCH_IDLE;
      cnt_r   <= '0;
      inst_r  <= 32'h0000_0000;
      flags_r <= IC_IF_NONE;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      inst_r  <= inst_s;
      flags_r <= flags_s;
    end
  end

  assign if_inst        = inst_r;
  assign if_adee        = flags_r.adee;
  assign if_adfe        = flags_r.adfe;
  assign if_inst_valid  = (state_r == FETCH_RESP) && !if_flush;
  assign if_delay_fetch = (state_r == FETCH_WAIT) || (state_r == FETCH_DRAIN);
  assign mem_en         = accept_s && reset;
  assign mem_addr       = mem_en ? word_addr_s : '0;

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Directed self-checking bench for imem_fetch_responder with a fixed-latency
// SRAM model returning 32'h1234_0000 | word address.
module tb_imem_fetch_responder;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req;
  logic [31:0]   if_pc;
  logic          if_flush;
  logic [31:0]   if_inst;
  logic          if_inst_valid;
  logic          if_delay_fetch;
  logic          if_adee;
  logic          if_adfe;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_rdata;

  int total = 0;
  int bad   = 0;
  int en_cnt = 0;
  logic [31:0] p1, p2;

  imem_fetch_responder #(
    .BASE_PC(32'hBFC0_0000), .DEPTH(1024), .AW(AW), .MEM_LAT(2)
  ) dut (
    .clk(clk), .reset(reset), .if_req(if_req), .if_pc(if_pc), .if_flush(if_flush),
    .if_inst(if_inst), .if_inst_valid(if_inst_valid), .if_delay_fetch(if_delay_fetch),
    .if_adee(if_adee), .if_adfe(if_adfe), .mem_en(mem_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Two-stage SRAM read pipeline
  always @(posedge clk) begin
    p1 <= mem_en ? (32'h1234_0000 | {22'd0, mem_addr}) : 32'hDEAD_BEEF;
    p2 <= p1;
    if (mem_en) en_cnt <= en_cnt + 1;
  end
  assign mem_rdata = p2;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; if_req = 1'b0; if_pc = 32'h0; if_flush = 1'b0;
    #2;
    total++;
    if ({if_inst, if_inst_valid, if_delay_fetch, if_adee, if_adfe, mem_en, mem_addr} !== '0) begin
      bad++; $display("FAIL reset_outputs: got inst=%h v=%b d=%b adee=%b adfe=%b en=%b addr=%h want all 0",
                      if_inst, if_inst_valid, if_delay_fetch, if_adee, if_adfe, mem_en, mem_addr);
    end
    next_cycle(); next_cycle();
    reset = 1'b1;
    next_cycle();
  endtask

  task automatic test_good_fetch();
    if_req = 1'b1; if_pc = 32'hBFC0_0000; #1;
    total++;
    if (mem_en !== 1'b1 || mem_addr !== 10'd0) begin
      bad++; $display("FAIL good_issue: got en=%b addr=%0d want en=1 addr=0", mem_en, mem_addr);
    end
    for (int c = 1; c <= 2; c++) begin
      next_cycle(); if_req = 1'b0; #1;
      total++;
      if (if_delay_fetch !== 1'b1 || if_inst_valid !== 1'b0 || mem_en !== 1'b0) begin
        bad++; $display("FAIL good_wait c=%0d: got d=%b v=%b en=%b want d=1 v=0 en=0", c, if_delay_fetch, if_inst_valid, mem_en);
      end
    end
    next_cycle(); #1;
    total++;
    if (if_inst_valid !== 1'b1 || if_inst !== 32'h1234_0000 || if_adee !== 1'b0 || if_adfe !== 1'b0 || if_delay_fetch !== 1'b0) begin
      bad++; $display("FAIL good_resp: got v=%b inst=%h adee=%b adfe=%b d=%b want v=1 inst=12340000 flags 0 d=0",
                      if_inst_valid, if_inst, if_adee, if_adfe, if_delay_fetch);
    end
    next_cycle(); #1;
    total++;
    if (if_inst_valid !== 1'b0 || if_inst !== 32'h1234_0000) begin
      bad++; $display("FAIL good_pulse: got v=%b inst=%h want v=0 inst=12340000", if_inst_valid, if_inst);
    end
  endtask

  task automatic test_errors();
    logic [31:0] pcs [3];
    logic [1:0]  want [3];
    int          en_before;
    pcs[0] = 32'hBFC0_0006; want[0] = 2'b10;
    pcs[1] = 32'hBFC0_1000; want[1] = 2'b01;
    pcs[2] = 32'hBFBF_FFFC; want[2] = 2'b01;
    for (int i = 0; i < 3; i++) begin
      en_before = en_cnt;
      if_req = 1'b1; if_pc = pcs[i];
      next_cycle(); if_req = 1'b0; #1;
      total++;
      if (if_inst_valid !== 1'b1 || {if_adee, if_adfe} !== want[i] || if_inst !== 32'h0 || if_delay_fetch !== 1'b0) begin
        bad++; $display("FAIL err_resp pc=%h: got v=%b flags=%b inst=%h d=%b want v=1 flags=%b inst=0 d=0",
                        pcs[i], if_inst_valid, {if_adee, if_adfe}, if_inst, if_delay_fetch, want[i]);
      end
      next_cycle(); #1;
      total++;
      if (if_inst_valid !== 1'b0 || if_adee !== 1'b0 || if_adfe !== 1'b0 || en_cnt !== en_before) begin
        bad++; $display("FAIL err_after pc=%h: got v=%b adee=%b adfe=%b en_pulses=%0d want 0 0 0 %0d",
                        pcs[i], if_inst_valid, if_adee, if_adfe, en_cnt, en_before);
      end
    end
  endtask

  task automatic test_last_word();
    if_req = 1'b1; if_pc = 32'hBFC0_0FFC; #1;
    total++;
    if (mem_en !== 1'b1 || mem_addr !== 10'd1023) begin
      bad++; $display("FAIL last_word_issue: got en=%b addr=%0d want en=1 addr=1023", mem_en, mem_addr);
    end
    next_cycle(); if_req = 1'b0;
    next_cycle(); next_cycle(); #1;
    total++;
    if (if_inst_valid !== 1'b1 || if_inst !== 32'h1234_03FF || if_adfe !== 1'b0) begin
      bad++; $display("FAIL last_word_resp: got v=%b inst=%h adfe=%b want v=1 inst=123403ff adfe=0", if_inst_valid, if_inst, if_adfe);
    end
    next_cycle();
  endtask

  task automatic test_flush_wait();
    if_req = 1'b1; if_pc = 32'hBFC0_0000;
    next_cycle(); if_req = 1'b0; if_flush = 1'b1; #1;
    total++;
    if (if_delay_fetch !== 1'b1 || if_inst_valid !== 1'b0) begin
      bad++; $display("FAIL flush_t1: got d=%b v=%b want d=1 v=0", if_delay_fetch, if_inst_valid);
    end
    next_cycle(); if_flush = 1'b0; #1;
    total++;
    if (if_delay_fetch !== 1'b1 || if_inst_valid !== 1'b0) begin
      bad++; $display("FAIL flush_t2: got d=%b v=%b want d=1 v=0", if_delay_fetch, if_inst_valid);
    end
    next_cycle(); if_req = 1'b1; if_pc = 32'hBFC0_0008; #1;
    total++;
    if (if_delay_fetch !== 1'b0 || if_inst_valid !== 1'b0 || mem_en !== 1'b1 || mem_addr !== 10'd2) begin
      bad++; $display("FAIL flush_t3: got d=%b v=%b en=%b addr=%0d want d=0 v=0 en=1 addr=2",
                      if_delay_fetch, if_inst_valid, mem_en, mem_addr);
    end
    next_cycle(); if_req = 1'b0; #1;
    total++;
    if (if_inst_valid !== 1'b0) begin
      bad++; $display("FAIL flush_no_stale: got v=%b inst=%h want v=0", if_inst_valid, if_inst);
    end
    next_cycle(); next_cycle(); #1;
    total++;
    if (if_inst_valid !== 1'b1 || if_inst !== 32'h1234_0002) begin
      bad++; $display("FAIL flush_refetch: got v=%b inst=%h want v=1 inst=12340002", if_inst_valid, if_inst);
    end
    next_cycle();
  endtask

  task automatic test_flush_idle_and_resp();
    if_req = 1'b1; if_flush = 1'b1; if_pc = 32'hBFC0_0004; #1;
    total++;
    if (mem_en !== 1'b0) begin
      bad++; $display("FAIL flush_idle_en: got en=%b want 0", mem_en);
    end
    next_cycle(); if_req = 1'b0; if_flush = 1'b0; #1;
    total++;
    if (if_delay_fetch !== 1'b0 || if_inst_valid !== 1'b0) begin
      bad++; $display("FAIL flush_idle_state: got d=%b v=%b want 0 0", if_delay_fetch, if_inst_valid);
    end
    // Flush landing on the response cycle suppresses the valid pulse.
    if_req = 1'b1; if_pc = 32'hBFC0_0006;
    next_cycle(); if_req = 1'b0; if_flush = 1'b1; #1;
    total++;
    if (if_inst_valid !== 1'b0) begin
      bad++; $display("FAIL flush_resp: got v=%b want 0", if_inst_valid);
    end
    next_cycle(); if_flush = 1'b0; #1;
    total++;
    if (if_inst_valid !== 1'b0 || if_delay_fetch !== 1'b0 || if_adee !== 1'b0) begin
      bad++; $display("FAIL flush_resp_after: got v=%b d=%b adee=%b want 0 0 0", if_inst_valid, if_delay_fetch, if_adee);
    end
  endtask

  task automatic test_reset_in_wait();
    if_req = 1'b1; if_pc = 32'hBFC0_0008;
    next_cycle(); if_req = 1'b0; #1;
    reset = 1'b0; #1;
    total++;
    if ({if_inst, if_inst_valid, if_delay_fetch, if_adee, if_adfe, mem_en} !== '0) begin
      bad++; $display("FAIL reset_wait: got inst=%h v=%b d=%b adee=%b adfe=%b en=%b want all 0",
                      if_inst, if_inst_valid, if_delay_fetch, if_adee, if_adfe, mem_en);
    end
    next_cycle(); reset = 1'b1;
    next_cycle(); if_req = 1'b1; if_pc = 32'hBFC0_0004;
    next_cycle(); if_req = 1'b0;
    next_cycle(); next_cycle(); #1;
    total++;
    if (if_inst_valid !== 1'b1 || if_inst !== 32'h1234_0001) begin
      bad++; $display("FAIL reset_refetch: got v=%b inst=%h want v=1 inst=12340001", if_inst_valid, if_inst);
    end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] pc;
    pc = 32'hBFC0_0010;
    if_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if_pc = pc; #1;
      total++;
      if (mem_en !== 1'b1 || mem_addr !== AW'(4 + 2 * k)) begin
        bad++; $display("FAIL b2b_issue k=%0d: got en=%b addr=%0d want en=1 addr=%0d", k, mem_en, mem_addr, 4 + 2 * k);
      end
      pc = pc + 32'd8;
      for (int c = 1; c <= 2; c++) begin
        next_cycle(); if_pc = pc; #1;
        total++;
        if (mem_en !== 1'b0 || if_inst_valid !== 1'b0) begin
          bad++; $display("FAIL b2b_busy k=%0d c=%0d: got en=%b v=%b want 0 0", k, c, mem_en, if_inst_valid);
        end
      end
      next_cycle(); #1;
      total++;
      if (if_inst_valid !== 1'b1 || if_inst !== (32'h1234_0000 | 32'(4 + 2 * k)) || mem_en !== 1'b0) begin
        bad++; $display("FAIL b2b_resp k=%0d: got v=%b inst=%h en=%b want v=1 inst=%h en=0",
                        k, if_inst_valid, if_inst, mem_en, 32'h1234_0000 | 32'(4 + 2 * k));
      end
      next_cycle();
    end
    if_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_good_fetch();
    test_errors();
    test_last_word();
    test_flush_wait();
    test_flush_idle_and_resp();
    test_reset_in_wait();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
